// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and helpers for the BCD counter slice
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int BCD_MAX_DIGITS = 6;

    // True when every one of the low `digits` nibbles is a decimal digit.
    function automatic logic bcd_valid(input logic [23:0] value, input int digits);
        logic ok = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++)
            if (i < digits && value[4*i+:4] > BCD_DIGIT_MAX)
                ok = 1'b0;
        return ok;
    endfunction

    // a > b, decided by the most significant differing digit.
    function automatic logic bcd_gt(input logic [23:0] a, input logic [23:0] b, input int digits);
        logic gt = 1'b0;
        logic done = 1'b0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--)
            if (i < digits && !done && a[4*i+:4] != b[4*i+:4]) begin
                gt = a[4*i+:4] > b[4*i+:4];
                done = 1'b1;
            end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one combinational BCD digit stepper with ripple carry/borrow
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    input  logic                   inc_en,
    input  logic                   dec_en,
    output logic [BCD_DIGIT_W-1:0] d_next,
    output logic                   carry_out,
    output logic                   borrow_out
);

    // Roll 9->0 on increment and 0->9 on decrement, passing the ripple upward.
    always_comb begin
        carry_out  = inc_en && d == BCD_DIGIT_MAX;
        borrow_out = dec_en && d == '0;
        d_next     = carry_out ? '0 : borrow_out ? BCD_DIGIT_MAX :
                     inc_en ? d + 4'd1 : dec_en ? d - 4'd1 : d;
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: N-digit up/down BCD modulo counter with clear, load and chainable pulses
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter logic [4*DIGITS-1:0] DEFAULT_MAX = 'h59
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                up_down,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic [4*DIGITS-1:0] max_bcd,
    output logic [4*DIGITS-1:0] q,
    output logic                carry,
    output logic                borrow,
    output logic                at_max,
    output logic                load_err
);

    logic [DIGITS:0]     inc;
    logic [DIGITS:0]     dec;
    logic [4*DIGITS-1:0] q_step;
    logic                over;
    logic                load_ok;
    logic                wrap_up;

    // The digit chain is seeded in the requested direction; the ripple out of the
    // top digit on the down path means q was all zeros.
    assign inc[0] = up_down;
    assign dec[0] = !up_down;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .d          (q[4*i+:4]),
            .inc_en     (inc[i]),
            .dec_en     (dec[i]),
            .d_next     (q_step[4*i+:4]),
            .carry_out  (inc[i+1]),
            .borrow_out (dec[i+1])
        );
    end

    assign at_max  = q == max_bcd;
    assign over    = bcd_gt(24'(q), 24'(max_bcd), DIGITS);
    assign load_ok = bcd_valid(24'(load_value), DIGITS) && !bcd_gt(24'(load_value), 24'(max_bcd), DIGITS);
    assign wrap_up = at_max || over || inc[DIGITS];

    // Count register: clear beats load beats tick; pulses last exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= clear ? '0 :
                        load ? (load_ok ? load_value : max_bcd) :
                        !tick ? q :
                        up_down ? (wrap_up ? '0 : q_step) :
                        (dec[DIGITS] || over) ? max_bcd : q_step;
            carry    <= !clear && !load && tick && up_down && wrap_up;
            borrow   <= !clear && !load && tick && dec[DIGITS];
            load_err <= !clear && load && !load_ok;
        end
    end

    // A non-BCD bound or parameter has no defined behaviour; catch it in simulation.
    a_max_valid: assert property (@(posedge clk) disable iff (!reset)
        DIGITS >= 1 && DIGITS <= BCD_MAX_DIGITS &&
        bcd_valid(24'(max_bcd), DIGITS) && bcd_valid(24'(DEFAULT_MAX), DIGITS));

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: randomized and directed checks of two counter instances against a decimal model
module tb_bcd_mod_counter;

    logic        clk = 0;
    logic        reset = 1;
    logic        tick = 0, up_down = 1, clear = 0, load = 0;
    logic [7:0]  lv2 = 0, mx2 = 8'h59, q2;
    logic [11:0] lv3 = 0, mx3 = 12'h999, q3;
    logic        carry2, borrow2, atmax2, lerr2;
    logic        carry3, borrow3, atmax3, lerr3;

    int checks = 0, fails = 0;
    int m2 = 0, m3 = 0;
    logic c2m = 0, b2m = 0, e2m = 0, c3m = 0, b3m = 0, e3m = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .DEFAULT_MAX(8'h59)) u2 (
        .clk(clk), .reset(reset), .tick(tick), .up_down(up_down), .clear(clear), .load(load),
        .load_value(lv2), .max_bcd(mx2), .q(q2), .carry(carry2), .borrow(borrow2),
        .at_max(atmax2), .load_err(lerr2));

    bcd_mod_counter #(.DIGITS(3), .DEFAULT_MAX(12'h999)) u3 (
        .clk(clk), .reset(reset), .tick(tick), .up_down(up_down), .clear(clear), .load(load),
        .load_value(lv3), .max_bcd(mx3), .q(q3), .carry(carry3), .borrow(borrow3),
        .at_max(atmax3), .load_err(lerr3));

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [23:0] b);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[4*i+:4]);
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [23:0] b, input int digits);
        logic ok = 1;
        for (int i = 0; i < digits; i++) if (b[4*i+:4] > 4'd9) ok = 0;
        return ok;
    endfunction

    // Decimal behavioural model of one clock edge.
    task automatic model_edge(input int digits, input logic [23:0] lv, input logic [23:0] mx,
                              inout int mq, output logic mc, output logic mb, output logic me);
        int maxd = bcd2int(mx);
        mc = 0; mb = 0; me = 0;
        if (clear) mq = 0;
        else if (load) begin
            if (bcd_ok(lv, digits) && bcd2int(lv) <= maxd) mq = bcd2int(lv);
            else begin mq = maxd; me = 1; end
        end else if (tick) begin
            if (up_down) begin
                if (mq >= maxd) begin mq = 0; mc = 1; end
                else mq = mq + 1;
            end else begin
                if (mq == 0) begin mq = maxd; mb = 1; end
                else if (mq > maxd) mq = maxd;
                else mq = mq - 1;
            end
        end
    endtask

    task automatic clk_edge();
        model_edge(2, 24'(lv2), 24'(mx2), m2, c2m, b2m, e2m);
        model_edge(3, 24'(lv3), 24'(mx3), m3, c3m, b3m, e3m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #3;
        checks++;
        if ({q2, carry2, borrow2, lerr2, q3, carry3, borrow3, lerr3} !== 24'h0) begin
            fails++;
            $display("FAIL reset: q2=%h c=%b b=%b e=%b q3=%h c=%b b=%b e=%b, want all zero",
                     q2, carry2, borrow2, lerr2, q3, carry3, borrow3, lerr3);
        end
        @(posedge clk);
        #1 reset = 1;
        m2 = 0; m3 = 0;
    endtask

    task automatic test_count_up();
        int ncarry = 0;
        mx2 = 8'h59; up_down = 1; tick = 1;
        for (int i = 1; i <= 60; i++) begin
            clk_edge();
            ncarry += int'(carry2);
            checks++;
            if ({q2, carry2, borrow2, lerr2} !== {8'(int2bcd(m2)), c2m, b2m, e2m}) begin
                fails++;
                $display("FAIL count_up step %0d: q=%h c=%b b=%b e=%b, want q=%h c=%b b=%b e=%b",
                         i, q2, carry2, borrow2, lerr2, 8'(int2bcd(m2)), c2m, b2m, e2m);
            end
        end
        tick = 0;
        checks++;
        if (ncarry != 1 || q2 !== 8'h00) begin
            fails++;
            $display("FAIL count_up_total: carries=%0d q=%h, want carries=1 q=00", ncarry, q2);
        end
    endtask

    task automatic test_count_down();
        logic [7:0] want_q[2] = '{8'h59, 8'h58};
        logic       want_b[2] = '{1'b1, 1'b0};
        up_down = 0; tick = 1;
        for (int i = 0; i < 2; i++) begin
            clk_edge();
            checks++;
            if ({q2, borrow2, carry2} !== {want_q[i], want_b[i], 1'b0} ||
                {q2, borrow2} !== {8'(int2bcd(m2)), b2m}) begin
                fails++;
                $display("FAIL count_down step %0d: q=%h b=%b c=%b, want q=%h b=%b c=0",
                         i, q2, borrow2, carry2, want_q[i], want_b[i]);
            end
        end
        tick = 0; up_down = 1;
    endtask

    task automatic test_load_clamp();
        logic [7:0] vals[3]   = '{8'h37, 8'h1A, 8'h12};
        logic [7:0] want_q[3] = '{8'h23, 8'h23, 8'h12};
        logic       want_e[3] = '{1'b1, 1'b1, 1'b0};
        mx2 = 8'h23; tick = 1; load = 1;
        for (int i = 0; i < 3; i++) begin
            lv2 = vals[i];
            clk_edge();
            checks++;
            if ({q2, lerr2, carry2, borrow2} !== {want_q[i], want_e[i], 2'b00} ||
                {q2, lerr2} !== {8'(int2bcd(m2)), e2m}) begin
                fails++;
                $display("FAIL load_clamp %h: q=%h e=%b c=%b b=%b, want q=%h e=%b c=0 b=0",
                         vals[i], q2, lerr2, carry2, borrow2, want_q[i], want_e[i]);
            end
        end
        load = 0; tick = 0;
        clk_edge();
        checks++;
        if (lerr2 !== 1'b0 || q2 !== 8'h12) begin
            fails++;
            $display("FAIL load_hold: q=%h e=%b, want q=12 e=0", q2, lerr2);
        end
    endtask

    task automatic test_three_digit();
        logic [11:0] start[2]  = '{12'h099, 12'h999};
        logic [11:0] want_q[2] = '{12'h100, 12'h000};
        logic        want_c[2] = '{1'b0, 1'b1};
        mx3 = 12'h999; lv2 = 8'h00;
        for (int i = 0; i < 2; i++) begin
            lv3 = start[i]; load = 1; tick = 0;
            clk_edge();
            load = 0; tick = 1; up_down = 1;
            clk_edge();
            tick = 0;
            checks++;
            if ({q3, carry3, borrow3} !== {want_q[i], want_c[i], 1'b0} ||
                {q3, carry3} !== {12'(int2bcd(m3)), c3m}) begin
                fails++;
                $display("FAIL three_digit from %h: q=%h c=%b b=%b, want q=%h c=%b b=0",
                         start[i], q3, carry3, borrow3, want_q[i], want_c[i]);
            end
        end
    endtask

    task automatic test_priority();
        mx2 = 8'h59; lv2 = 8'h45; load = 1;
        clk_edge();
        clear = 1; tick = 1; up_down = 1; lv2 = 8'h37;
        clk_edge();
        clear = 0; load = 0; tick = 0;
        checks++;
        if ({q2, carry2, borrow2, lerr2} !== {8'h00, 3'b000} ||
            {q2, carry2, borrow2, lerr2} !== {8'(int2bcd(m2)), c2m, b2m, e2m}) begin
            fails++;
            $display("FAIL priority_clear: q=%h c=%b b=%b e=%b, want q=00 c=0 b=0 e=0",
                     q2, carry2, borrow2, lerr2);
        end
        lv2 = 8'h45; load = 1;
        clk_edge();
        load = 0; mx2 = 8'h23; tick = 1; up_down = 1;
        clk_edge();
        tick = 0;
        checks++;
        if ({q2, carry2} !== {8'h00, 1'b1} || {q2, carry2} !== {8'(int2bcd(m2)), c2m}) begin
            fails++;
            $display("FAIL lowered_max: q=%h c=%b, want q=00 c=1", q2, carry2);
        end
    endtask

    task automatic test_async_reset();
        mx2 = 8'h59; lv2 = 8'h31; load = 1;
        clk_edge();
        load = 0; tick = 1; up_down = 1;
        #3 reset = 0;
        #1;
        checks++;
        if ({q2, carry2, borrow2, lerr2} !== 11'h0) begin
            fails++;
            $display("FAIL async_reset: q=%h c=%b b=%b e=%b, want all zero before clk", q2, carry2, borrow2, lerr2);
        end
        @(posedge clk);
        #1 reset = 1;
        m2 = 0; m3 = 0;
        clk_edge();
        tick = 0;
        checks++;
        if ({q2, carry2} !== {8'h01, 1'b0} || q2 !== 8'(int2bcd(m2))) begin
            fails++;
            $display("FAIL after_reset_tick: q=%h c=%b, want q=01 c=0", q2, carry2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom % 16) == 0;
            load = ($urandom % 6) == 0;
            tick = $urandom % 2;
            up_down = $urandom % 2;
            lv2 = ($urandom % 2) ? 8'(int2bcd($urandom % 100)) : 8'($urandom);
            lv3 = ($urandom % 2) ? 12'(int2bcd($urandom % 1000)) : 12'($urandom);
            if ($urandom % 20 == 0) begin
                mx2 = 8'(int2bcd($urandom % 100));
                mx3 = 12'(int2bcd($urandom % 1000));
            end
            clk_edge();
            checks++;
            if ({q2, carry2, borrow2, lerr2, atmax2} !==
                {8'(int2bcd(m2)), c2m, b2m, e2m, 8'(int2bcd(m2)) == mx2}) begin
                fails++;
                $display("FAIL random2 #%0d: q=%h c=%b b=%b e=%b m=%b, want q=%h c=%b b=%b e=%b max=%h",
                         i, q2, carry2, borrow2, lerr2, atmax2, 8'(int2bcd(m2)), c2m, b2m, e2m, mx2);
            end
            checks++;
            if ({q3, carry3, borrow3, lerr3, atmax3} !==
                {12'(int2bcd(m3)), c3m, b3m, e3m, 12'(int2bcd(m3)) == mx3}) begin
                fails++;
                $display("FAIL random3 #%0d: q=%h c=%b b=%b e=%b m=%b, want q=%h c=%b b=%b e=%b max=%h",
                         i, q3, carry3, borrow3, lerr3, atmax3, 12'(int2bcd(m3)), c3m, b3m, e3m, mx3);
            end
        end
        clear = 0; load = 0; tick = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_three_digit();
        test_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
